// File: rtl/kgp_rout_uart_tx.sv
// kgp_rout_uart_tx: captures each new value of the core's rout bus into a
// small FIFO and sends every queued word as two 8N1 UART frames, high byte
// first. The line idles high and is driven from a flop, so it never glitches.
//
// Push/pop rule: a push is requested whenever rout differs from the last
// captured value; it is accepted when the FIFO has room or when the
// transmitter pops on the same edge, otherwise it is dropped and overflow
// sticks. The transmitter pops only from IDLE when the FIFO is non-empty.
module kgp_rout_uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   rout,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            byte_sel_q, byte_sel_d;
  logic [15:0]     hold_q, hold_d;
  logic            tx_q, tx_d;
  logic [15:0]     last_val_q, last_val_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic [7:0]      cur_byte;

  // Capture and FIFO bookkeeping: change detection, push acceptance, pointers, count.
  always_comb begin
    push_req   = (rout != last_val_q);
    pop        = (state_q == S_IDLE) && (count_q != '0);
    push_ok    = push_req && ((count_q < DEPTH_N) || pop);
    last_val_d = push_req ? rout : last_val_q;
    overflow_d = overflow_q | (push_req & ~push_ok);
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM next-state: bit timing, byte sequencing and the next tx level.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    cur_byte   = byte_sel_q ? hold_q[7:0] : hold_q[15:8];
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          hold_d     = mem_q[rd_ptr_q];
          byte_sel_d = 1'b0;
          cnt_d      = '0;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!byte_sel_q) begin
            // Low byte follows immediately, no idle gap between the two frames.
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any frame in flight and empties the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_sel_q <= 1'b0;
      hold_q     <= 16'h0000;
      tx_q       <= 1'b1;
      last_val_q <= 16'h0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      last_val_q <= last_val_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rout;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_kgp_rout_uart_tx.sv
// Bench for kgp_rout_uart_tx: directed rout sequences, a UART line receiver
// that pops expected words from a queue, and cycle-exact line/flag checks.
module tb_kgp_rout_uart_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] rout;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int peak  = 0;

  logic [15:0] exp_q[$];
  int          start_q[$];

  kgp_rout_uart_tx #(.CLKS_PER_BIT(8), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .rout       (rout),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic do_reset();
    rout  = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
    repeat (200) step();
    check({name, "_idle_busy"}, 32'(busy), 0);
    check({name, "_idle_count"}, 32'(fifo_count), 0);
    check({name, "_idle_tx"}, 32'(tx), 1);
  endtask

  // Scoreboard monitor: 8N1 receiver sampling mid-bit on the falling clock edge
  logic        rx_busy = 1'b0;
  logic        rx_hi_done = 1'b0;
  int          rx_n = 0;
  logic [7:0]  rx_shift = 8'h00;
  logic [7:0]  rx_hi = 8'h00;
  logic [15:0] rx_got;
  logic [15:0] rx_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy    = 1'b0;
      rx_hi_done = 1'b0;
      rx_n       = 0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy  = 1'b1;
        rx_n     = 0;
        rx_shift = 8'h00;
        if (!rx_hi_done) start_q.push_back(cyc);
      end
    end else begin
      rx_n++;
      if (rx_n == 4) begin
        check("rx_start_bit", 32'(tx), 0);
      end else if (rx_n >= 12 && rx_n <= 68 && (rx_n % 8) == 4) begin
        rx_shift = {tx, rx_shift[7:1]};
      end else if (rx_n == 76) begin
        check("rx_stop_bit", 32'(tx), 1);
        rx_busy = 1'b0;
        if (!rx_hi_done) begin
          rx_hi      = rx_shift;
          rx_hi_done = 1'b1;
        end else begin
          rx_hi_done = 1'b0;
          rx_got     = {rx_hi, rx_shift};
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_word: got %h, no word expected (cycle %0d)", rx_got, cyc);
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_word", 32'(rx_got), 32'(rx_exp));
          end
        end
      end
    end
  end

  // Directed stimulus
  int bits_a53c[20] = '{0, 1,0,1,0,0,1,0,1, 1,  0, 0,0,1,1,1,1,0,0, 1};

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    rout  = 16'h0000;

    // 1: rout stays zero, nothing must happen
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step();
      if (i % 50 == 0) begin
        check("t1_tx", 32'(tx), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_count", 32'(fifo_count), 0);
      end
    end

    // 2: single word A53C, exact line waveform and busy timing
    do_reset();
    rout = 16'hA53C;
    exp_q.push_back(16'hA53C);
    step();
    check("t2_tx_before_start", 32'(tx), 1);
    check("t2_count_after_push", 32'(fifo_count), 1);
    for (int c = 0; c < 160; c++) begin
      step();
      check($sformatf("t2_line_bit%0d", c / 8), 32'(tx), 32'(bits_a53c[c / 8]));
      if (c == 159) check("t2_busy_last", 32'(busy), 1);
    end
    step();
    check("t2_busy_fall", 32'(busy), 0);
    check("t2_tx_idle", 32'(tx), 1);
    drain("t2_drain", 400);

    // 3: 1..12 on consecutive edges; 10..12 dropped
    do_reset();
    peak = 0;
    for (int v = 1; v <= 12; v++) begin
      rout = 16'(v);
      if (v <= 9) exp_q.push_back(16'(v));
      step();
      if (v == 9) begin
        check("t3_count_full", 32'(fifo_count), 8);
        check("t3_overflow_pre", 32'(overflow), 0);
      end
      if (v == 10) check("t3_overflow_set", 32'(overflow), 1);
    end
    check("t3_overflow_hold", 32'(overflow), 1);
    drain("t3_drain", 3000);
    check("t3_peak_count", 32'(peak), 8);
    check("t3_overflow_sticky", 32'(overflow), 1);

    // 4: A,A,B,A each held 3 cycles; three words, 161 cycles apart
    do_reset();
    base = start_q.size();
    rout = 16'h1234; exp_q.push_back(16'h1234);
    repeat (6) step();
    rout = 16'hBEEF; exp_q.push_back(16'hBEEF);
    repeat (3) step();
    rout = 16'h1234; exp_q.push_back(16'h1234);
    repeat (3) step();
    drain("t4_drain", 1000);
    check("t4_word_count", 32'(start_q.size() - base), 3);
    if (start_q.size() - base == 3) begin
      check("t4_gap1", 32'(start_q[base + 1] - start_q[base]), 161);
      check("t4_gap2", 32'(start_q[base + 2] - start_q[base + 1]), 161);
    end

    // 5: reset mid high byte of 00FF, then the word is sent once in full
    do_reset();
    rout = 16'h00FF;
    step();
    step();
    check("t5_tx_start", 32'(tx), 0);
    repeat (50) step();
    check("t5_busy_pre", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_tx_async", 32'(tx), 1);
    check("t5_busy_async", 32'(busy), 0);
    check("t5_count_async", 32'(fifo_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h00FF);
    step();
    check("t5_recapture", 32'(fifo_count), 1);
    step();
    check("t5_restart_tx", 32'(tx), 0);
    drain("t5_drain", 400);

    // 6: full FIFO, new value on the pop edge is accepted
    do_reset();
    for (int v = 1; v <= 9; v++) begin
      rout = 16'(v);
      exp_q.push_back(16'(v));
      step();
    end
    check("t6_count_full", 32'(fifo_count), 8);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check("t6_idle_reached", 32'(busy), 0);
    rout = 16'h000A;
    exp_q.push_back(16'h000A);
    step();
    check("t6_count_kept", 32'(fifo_count), 8);
    check("t6_no_overflow", 32'(overflow), 0);
    check("t6_busy_popped", 32'(busy), 1);
    drain("t6_drain", 3000);
    check("t6_overflow_end", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
